activity_monitor: RTL

- Parametrised successor to the pedometer statistics path: one synchronous block replaces the separate step counter, 1 Hz divider, over-32 counter and high-activity counter.
- Samples a raw step pulse in the CLK domain and counts steps per second.
- Reports total steps, the last one-second rate, seconds above a low threshold within a start window, and the longest consecutive run at or above a high threshold.
- Sits between the pulse generator and the output selector.

---
 rtl/activity_pkg.sv | 11 +
 rtl/step_sync_edge.sv | 26 ++
 rtl/activity_monitor.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/activity_pkg.sv
// Shared state encoding and default constants for the activity statistics path.
package activity_pkg;

    typedef enum logic [1:0] {StIdle, StWindow, StRun} act_state_e;

    localparam int unsigned TICK_DIV_DEF = 100000000;
    localparam int unsigned THR_LO_DEF   = 32;
    localparam int unsigned THR_HI_DEF   = 64;
    localparam int unsigned DISP_MAX_DEF = 9999;

endpackage

// File: rtl/step_sync_edge.sv
// Two-flop synchroniser for an asynchronous pulse input, followed by a
// single-cycle rising-edge detector.
module step_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o
);

    logic meta_q, sync_q, prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/activity_monitor.sv
// Step statistics: total steps, per-second rate, low-threshold seconds within
// the start window and longest run of high-threshold seconds.
module activity_monitor
    import activity_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEF,
    parameter int unsigned CNT_W    = 14,
    parameter int unsigned RATE_W   = 8,
    parameter int unsigned THR_LO   = THR_LO_DEF,
    parameter int unsigned THR_HI   = THR_HI_DEF,
    parameter int unsigned WINDOW_S = 9,
    parameter int unsigned DISP_MAX = DISP_MAX_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic              STEP,
    output logic [CNT_W-1:0]  STEP_TOTAL,
    output logic              SI,
    output logic [RATE_W-1:0] RATE_LAST,
    output logic [CNT_W-1:0]  SEC_OVER_LO,
    output logic [CNT_W-1:0]  HI_RUN_MAX,
    output logic              SEC_TICK,
    output logic              BUSY
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SEC_W = $clog2(WINDOW_S + 1);

    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [SEC_W-1:0]  SEC_LAST = SEC_W'(WINDOW_S - 1);
    localparam logic [RATE_W-1:0] RATE_MAX = '1;
    localparam logic [RATE_W-1:0] THR_LO_R = RATE_W'(THR_LO);
    localparam logic [RATE_W-1:0] THR_HI_R = RATE_W'(THR_HI);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DISP_MAX);

    act_state_e        state_q, state_d;
    logic [PRE_W-1:0]  presc_q, presc_d;
    logic [RATE_W-1:0] rate_q, rate_d;
    logic [RATE_W-1:0] rate_last_q, rate_last_d;
    logic [CNT_W-1:0]  total_q, total_d;
    logic              si_q, si_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic [CNT_W-1:0]  over_lo_q, over_lo_d;
    logic [CNT_W-1:0]  run_q, run_d;
    logic [CNT_W-1:0]  run_max_q, run_max_d;

    logic step_rise, busy, step_ev, tick;
    logic [CNT_W-1:0] run_next;

    step_sync_edge u_step_sync (
        .clk_i  (CLK),
        .rst_ni (RESET),
        .async_i(STEP),
        .rise_o (step_rise)
    );

    always_comb begin
        busy        = (state_q != StIdle);
        step_ev     = step_rise & busy;
        tick        = busy && (presc_q == PRE_LAST);
        state_d     = state_q;
        presc_d     = presc_q;
        rate_d      = rate_q;
        rate_last_d = rate_last_q;
        total_d     = total_q;
        si_d        = si_q;
        sec_d       = sec_q;
        over_lo_d   = over_lo_q;
        run_d       = run_q;
        run_max_d   = run_max_q;
        run_next    = '0;

        if (step_ev) begin
            if (total_q < CNT_MAX) total_d = total_q + 1'b1;
            else                   si_d    = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (START) begin
                    state_d   = StWindow;
                    sec_d     = '0;
                    over_lo_d = '0;
                    run_d     = '0;
                    run_max_d = '0;
                end
            end
            StWindow, StRun: begin
                if (!START) begin
                    // Leaving wins over a coincident tick; the partial second is dropped.
                    state_d = StIdle;
                    presc_d = '0;
                    rate_d  = '0;
                end else begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        rate_last_d = rate_q;
                        // A step landing on the tick belongs to the new second.
                        rate_d = RATE_W'(step_ev);
                        if (rate_q >= THR_HI_R) begin
                            run_next = (run_q < CNT_MAX) ? run_q + 1'b1 : run_q;
                        end
                        run_d = run_next;
                        if (run_next > run_max_q) run_max_d = run_next;
                        if (state_q == StWindow) begin
                            if (rate_q > THR_LO_R) over_lo_d = over_lo_q + 1'b1;
                            sec_d = sec_q + 1'b1;
                            if (sec_q == SEC_LAST) state_d = StRun;
                        end
                    end else if (step_ev && rate_q != RATE_MAX) begin
                        rate_d = rate_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= StIdle;
            presc_q     <= '0;
            rate_q      <= '0;
            rate_last_q <= '0;
            total_q     <= '0;
            si_q        <= 1'b0;
            sec_q       <= '0;
            over_lo_q   <= '0;
            run_q       <= '0;
            run_max_q   <= '0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            rate_q      <= rate_d;
            rate_last_q <= rate_last_d;
            total_q     <= total_d;
            si_q        <= si_d;
            sec_q       <= sec_d;
            over_lo_q   <= over_lo_d;
            run_q       <= run_d;
            run_max_q   <= run_max_d;
        end
    end

    assign STEP_TOTAL  = total_q;
    assign SI          = si_q;
    assign RATE_LAST   = rate_last_q;
    assign SEC_OVER_LO = over_lo_q;
    assign HI_RUN_MAX  = run_max_q;
    assign SEC_TICK    = tick;
    assign BUSY        = busy;

endmodule
